// File: rtl/mem_rr_arbiter_pkg.sv
// Shared memory-bus request/response types for the SoC memory path.
// The arbiter, its interface and every requester use these, so they live
// in one package rather than being redeclared per file.
package mem_rr_arbiter_pkg;

    // Request from a master towards the address decoder.
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    // Response from the decoder back to a master.
    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    localparam mem_in_type  init_mem_in  = '0;
    localparam mem_out_type init_mem_out = '0;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// One memory bus channel: a request travelling towards the memory map and
// the matching response travelling back. The requester holds the master
// modport, the side that answers holds the slave modport.
interface mem_rr_arbiter_if;
    import mem_rr_arbiter_pkg::*;

    mem_in_type  mem_in;
    mem_out_type mem_out;

    modport master (output mem_in, input mem_out);
    modport slave  (input mem_in, output mem_out);
endinterface

// File: rtl/mem_rr_arbiter.sv
// Three-port round-robin arbiter for the shared SoC memory bus.
// Port 0 = instruction fetch, port 1 = data, port 2 = DMA/debug.
// Each port owns a single pending slot; one transaction is in flight
// downstream at a time and its response is routed back to the owner only.
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to enable a WAIT watchdog
// that answers a silent slave with a bus error after TIMEOUT cycles.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    mem_rr_arbiter_if.slave   port0,
    mem_rr_arbiter_if.slave   port1,
    mem_rr_arbiter_if.slave   port2,
    mem_rr_arbiter_if.master  mem,
    output logic [2:0]        grant,
    output logic              busy,
    output logic [2:0]        overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // A watchdog limit outside 1..65535 is a build error, not a silent wrap.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_rr_arbiter: TIMEOUT must be within 1..65535");
    end

    state_t      state_reg;
    logic [1:0]  rr_ptr_reg;
    logic [1:0]  owner_reg;
    logic [2:0]  grant_reg;
    logic        busy_reg;
    logic [2:0]  pending_reg;
    logic [2:0]  occupied_reg;
    logic [2:0]  overrun_reg;
    mem_in_type  mem_in_reg;
    mem_in_type  slot_reg [3];

    logic [2:0]  pending_next;
    logic [2:0]  occupied_next;

    mem_in_type  port_req [3];
    mem_out_type port_rsp [3];
    logic [2:0]  req_pulse;
    logic [2:0]  done_port;
    logic [2:0]  accept;
    logic [2:0]  drop;

    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [2:0]  pick_onehot;

    logic        wdog_fire;
    logic        resp_done;
    mem_out_type resp_word;

    // Flatten the three named ports so the per-port logic can be generated.
    assign port_req[0] = port0.mem_in;
    assign port_req[1] = port1.mem_in;
    assign port_req[2] = port2.mem_in;
    assign port0.mem_out = port_rsp[0];
    assign port1.mem_out = port_rsp[1];
    assign port2.mem_out = port_rsp[2];

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog_reg;

    // Watchdog: cleared on issue, counts every WAIT cycle without a response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_reg <= '0;
        end else if (state_reg == ST_ISSUE) begin
            wdog_reg <= '0;
        end else if (state_reg == ST_WAIT && !mem.mem_out.mem_ready) begin
            wdog_reg <= wdog_reg + 1'b1;
        end
    end

    // A real response in the expiry cycle takes priority over the error.
    assign wdog_fire = (state_reg == ST_WAIT) && !mem.mem_out.mem_ready &&
                       (wdog_reg == WDOG_W'(TIMEOUT));
`else
    assign wdog_fire = 1'b0;
`endif

    // Completion of the in-flight transaction; slave responses outside WAIT are stale.
    assign resp_done = (state_reg == ST_WAIT) && (mem.mem_out.mem_ready || wdog_fire);
    assign resp_word = mem.mem_out.mem_ready ? mem.mem_out
                                             : mem_out_type'({1'b1, 1'b1, 32'h0});

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_port
            assign req_pulse[gi] = port_req[gi].mem_valid;
            // The owner's slot frees in its response cycle, so a master may
            // chain its next request on the same cycle it sees mem_ready.
            assign done_port[gi] = resp_done && grant_reg[gi];
            assign accept[gi]    = req_pulse[gi] && (!occupied_reg[gi] || done_port[gi]);
            assign drop[gi]      = req_pulse[gi] && occupied_reg[gi] && !done_port[gi];
            assign port_rsp[gi]  = done_port[gi] ? resp_word : init_mem_out;
        end
    endgenerate

    // Round-robin pick: first pending port at or after rr_ptr, modulo 3.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            int cand;
            cand = int'(rr_ptr_reg) + k;
            if (cand >= 3) begin
                cand = cand - 3;
            end
            if (pending_reg[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(cand);
            end
        end
    end

    assign pick_onehot = 3'b001 << pick_idx;

    // Slot bookkeeping: grant clears pending, response clears occupied.
    always_comb begin
        pending_next  = pending_reg | accept;
        occupied_next = (occupied_reg & ~done_port) | accept;
        if (state_reg == ST_IDLE && pick_valid) begin
            pending_next = (pending_reg & ~pick_onehot) | accept;
        end
    end

    // Request payload capture; only meaningful while the pending bit is set.
    always_ff @(posedge clock) begin
        for (int p = 0; p < 3; p++) begin
            if (accept[p]) begin
                slot_reg[p] <= port_req[p];
            end
        end
    end

    // Arbitration FSM with registered downstream request and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= 2'd0;
            owner_reg    <= 2'd0;
            grant_reg    <= 3'b000;
            busy_reg     <= 1'b0;
            pending_reg  <= 3'b000;
            occupied_reg <= 3'b000;
            overrun_reg  <= 3'b000;
            mem_in_reg   <= init_mem_in;
        end else begin
            pending_reg  <= pending_next;
            occupied_reg <= occupied_next;
            overrun_reg  <= overrun_reg | drop;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        mem_in_reg           <= slot_reg[pick_idx];
                        mem_in_reg.mem_valid <= 1'b1;
                        grant_reg            <= pick_onehot;
                        owner_reg            <= pick_idx;
                        busy_reg             <= 1'b1;
                        state_reg            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_in_reg <= init_mem_in;
                    state_reg  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (resp_done) begin
                        rr_ptr_reg <= (owner_reg == 2'd2) ? 2'd0 : owner_reg + 2'd1;
                        grant_reg  <= 3'b000;
                        busy_reg   <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    mem_in_reg <= init_mem_in;
                    grant_reg  <= 3'b000;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_in = mem_in_reg;
    assign grant      = grant_reg;
    assign busy       = busy_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: a cycle-by-cycle vector table for the
// arbitration sequences, then hand-written reset and watchdog sequences.
// Inputs change 2 time units after the rising edge; outputs are sampled
// 6 units after it.
module tb_mem_rr_arbiter;
    import mem_rr_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] overrun;

    mem_rr_arbiter_if port0_if ();
    mem_rr_arbiter_if port1_if ();
    mem_rr_arbiter_if port2_if ();
    mem_rr_arbiter_if mem_if ();

    always #5 clock = ~clock;

    mem_rr_arbiter #(.TIMEOUT(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .port0   (port0_if),
        .port1   (port1_if),
        .port2   (port2_if),
        .mem     (mem_if),
        .grant   (grant),
        .busy    (busy),
        .overrun (overrun)
    );

    typedef struct {
        logic [2:0]  pulse;
        logic        s_ready;
        logic [31:0] s_rdata;
        logic        exp_valid;
        logic [1:0]  exp_port;
        logic [2:0]  exp_grant;
        logic        exp_busy;
        logic [2:0]  exp_overrun;
        logic [2:0]  exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] pulse, input logic s_ready,
                                input logic [31:0] s_rdata, input logic ev,
                                input logic [1:0] ep, input logic [2:0] eg,
                                input logic eb, input logic [2:0] eo,
                                input logic [2:0] er, input logic [31:0] erd);
        vec_t v;
        v.pulse = pulse;      v.s_ready = s_ready;  v.s_rdata = s_rdata;
        v.exp_valid = ev;     v.exp_port = ep;      v.exp_grant = eg;
        v.exp_busy = eb;      v.exp_overrun = eo;   v.exp_ready = er;
        v.exp_rdata = erd;
        return v;
    endfunction

    // Distinct payload per port so routing mistakes show up in the address.
    function automatic mem_in_type payload(input int p);
        mem_in_type v;
        case (p)
            0:       v = '{mem_valid: 1'b1, mem_instr: 1'b1, mem_addr: 32'h0000_0100,
                           mem_wdata: 32'h0, mem_wstrb: 4'h0};
            1:       v = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h8000_0200,
                           mem_wdata: 32'hA5A5_0001, mem_wstrb: 4'hF};
            default: v = '{mem_valid: 1'b1, mem_instr: 1'b0, mem_addr: 32'h1000_0300,
                           mem_wdata: 32'h5A5A_0002, mem_wstrb: 4'h3};
        endcase
        return v;
    endfunction

    // Garbage on the payload lines outside the pulse cycle.
    function automatic mem_in_type junk(input int p);
        mem_in_type v;
        v = '{mem_valid: 1'b0, mem_instr: 1'b1, mem_addr: 32'hBAD0_0000 + 32'(p),
              mem_wdata: 32'hFFFF_FFFF, mem_wstrb: 4'hF};
        return v;
    endfunction

    function automatic mem_out_type port_out(input int p);
        case (p)
            0:       return port0_if.mem_out;
            1:       return port1_if.mem_out;
            default: return port2_if.mem_out;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] pulse, input logic s_ready, input logic [31:0] s_rdata);
        port0_if.mem_in = pulse[0] ? payload(0) : junk(0);
        port1_if.mem_in = pulse[1] ? payload(1) : junk(1);
        port2_if.mem_in = pulse[2] ? payload(2) : junk(2);
        mem_if.mem_out  = mem_out_type'({s_ready, 1'b0, s_rdata});
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic log_txn(input string tag);
        for (int p = 0; p < 3; p++) begin
            mem_out_type o;
            o = port_out(p);
            if (o.mem_ready) begin
                $display("%s txn port%0d rdata=%08h err=%0d", tag, p, o.mem_rdata, o.mem_error);
            end
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [1:0] ep,
                             input logic [2:0] eg, input logic eb, input logic [2:0] eo,
                             input logic [2:0] er, input logic er_err, input logic [31:0] erd);
        mem_in_type  exp_in;
        mem_out_type exp_out;
        exp_in = ev ? payload(int'(ep)) : init_mem_in;
        chk({tag, " mem_in"}, mem_if.mem_in, exp_in);
        chk({tag, " grant"}, grant, eg);
        chk({tag, " busy"}, busy, eb);
        chk({tag, " overrun"}, overrun, eo);
        for (int p = 0; p < 3; p++) begin
            exp_out = er[p] ? mem_out_type'({1'b1, er_err, erd}) : init_mem_out;
            chk($sformatf("%s port%0d_out", tag, p), port_out(p), exp_out);
        end
        log_txn(tag);
    endtask

    initial begin
        // Three requests at once from rr_ptr=0: served 0,1,2, stale ready in IDLE ignored.
        vecs.push_back(mk(3'b111, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 0, 3'b001, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'h0000_0013, 0, 0, 3'b001, 1, 3'b000, 3'b001, 32'h0000_0013));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 1, 3'b010, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'h1111_2222, 0, 0, 3'b010, 1, 3'b000, 3'b010, 32'h1111_2222));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 2, 3'b100, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'h3333_4444, 0, 0, 3'b100, 1, 3'b000, 3'b100, 32'h3333_4444));
        vecs.push_back(mk(3'b000, 1, 32'hBAD0_0000, 0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        // Single port-1 read; ready during ISSUE is stale, real one in WAIT.
        vecs.push_back(mk(3'b010, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'hBAD1_1111, 1, 1, 3'b010, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'hDEAD_BEEF, 0, 0, 3'b010, 1, 3'b000, 3'b010, 32'hDEAD_BEEF));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        // Port 2 pulses again while occupied: overrun sticky, second never issued.
        vecs.push_back(mk(3'b100, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 2, 3'b100, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b100, 0, 32'h0,         0, 0, 3'b100, 1, 3'b000, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b100, 1, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'hC0DE_0002, 0, 0, 3'b100, 1, 3'b100, 3'b100, 32'hC0DE_0002));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        // Port 0 re-requests on its response cycle; port 1 still gets the next slot.
        vecs.push_back(mk(3'b001, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 0, 3'b001, 1, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b010, 0, 32'h0,         0, 0, 3'b001, 1, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b001, 1, 32'h0D0D_0001, 0, 0, 3'b001, 1, 3'b100, 3'b001, 32'h0D0D_0001));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 1, 3'b010, 1, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'h0D0D_0002, 0, 0, 3'b010, 1, 3'b100, 3'b010, 32'h0D0D_0002));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 0, 32'h0,         1, 0, 3'b001, 1, 3'b100, 3'b000, 32'h0));
        vecs.push_back(mk(3'b000, 1, 32'h0D0D_0003, 0, 0, 3'b001, 1, 3'b100, 3'b001, 32'h0D0D_0003));
        vecs.push_back(mk(3'b000, 0, 32'h0,         0, 0, 3'b000, 0, 3'b100, 3'b000, 32'h0));

        // Reset state.
        drive(3'b000, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        #2;
        check_all("reset", 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        reset = 1'b0;

        // Table-driven arbitration sequences.
        foreach (vecs[i]) begin
            next_cycle();
            drive(vecs[i].pulse, vecs[i].s_ready, vecs[i].s_rdata);
            #4;
            check_all($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_port,
                      vecs[i].exp_grant, vecs[i].exp_busy, vecs[i].exp_overrun,
                      vecs[i].exp_ready, 1'b0, vecs[i].exp_rdata);
        end

        // Reset asserted in WAIT; slave answers right after release.
        next_cycle(); drive(3'b010, 1'b0, 32'h0);
        next_cycle(); drive(3'b000, 1'b0, 32'h0);
        next_cycle(); drive(3'b000, 1'b0, 32'h0); #4;
        check_all("rst_issue", 1, 1, 3'b010, 1, 3'b100, 3'b000, 0, 32'h0);
        next_cycle(); drive(3'b000, 1'b0, 32'h0); #4;
        check_all("rst_wait", 0, 0, 3'b010, 1, 3'b100, 3'b000, 0, 32'h0);
        reset = 1'b1;
        #1;
        check_all("rst_async", 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle(); drive(3'b000, 1'b1, 32'hFEED_0001); #4;
        check_all("rst_late_rsp", 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); drive(3'b000, 1'b0, 32'h0); #4;
            check_all($sformatf("rst_quiet%0d", k), 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        end

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Silent slave on port 0: error response in the 9th WAIT cycle, late ready dropped.
        next_cycle(); drive(3'b001, 1'b0, 32'h0);
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            drive(3'b000, (k == 13), (k == 13) ? 32'h0000_0099 : 32'h55AA_55AA);
            #4;
            if (k == 2)
                check_all("to_issue", 1, 0, 3'b001, 1, 3'b000, 3'b000, 0, 32'h0);
            else if (k >= 3 && k <= 10)
                check_all($sformatf("to_wait%0d", k), 0, 0, 3'b001, 1, 3'b000, 3'b000, 0, 32'h0);
            else if (k == 11)
                check_all("to_fire", 0, 0, 3'b001, 1, 3'b000, 3'b001, 1, 32'h0);
            else if (k >= 12)
                check_all($sformatf("to_after%0d", k), 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        end
        // Real response landing in the expiry cycle wins over the error.
        next_cycle(); drive(3'b010, 1'b0, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            next_cycle();
            drive(3'b000, (k == 11), (k == 11) ? 32'h1234_5678 : 32'h0);
            #4;
            if (k == 10)
                check_all("race_pre", 0, 0, 3'b010, 1, 3'b000, 3'b000, 0, 32'h0);
            else if (k == 11)
                check_all("race_win", 0, 0, 3'b010, 1, 3'b000, 3'b010, 0, 32'h1234_5678);
            else if (k == 12)
                check_all("race_idle", 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        end
`else
        // Without the watchdog WAIT holds well past TIMEOUT until the slave answers.
        next_cycle(); drive(3'b010, 1'b0, 32'h0);
        for (int k = 1; k <= 22; k++) begin
            next_cycle();
            drive(3'b000, (k == 21), (k == 21) ? 32'h0BAD_F00D : 32'h0);
            #4;
            if (k >= 3 && k <= 20)
                check_all($sformatf("hold%0d", k), 0, 0, 3'b010, 1, 3'b000, 3'b000, 0, 32'h0);
            else if (k == 21)
                check_all("hold_rsp", 0, 0, 3'b010, 1, 3'b000, 3'b010, 0, 32'h0BAD_F00D);
            else if (k == 22)
                check_all("hold_idle", 0, 0, 3'b000, 0, 3'b000, 3'b000, 0, 32'h0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
